// File: rtl/if_id_hazard_stage.sv
// IF/ID pipeline register with load-use hazard detection, flush handling and sticky HALT latch.
// Optional stall counter output is enabled by defining IF_ID_STALL_COUNTER_EN.
module if_id_hazard_stage #(
    parameter int               len         = 32,
    parameter logic [len-1:0]   NOP         = 32'h00000000,
    parameter logic [5:0]       HALT_OPCODE = 6'b111111
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [len-1:0]   in_instruction,
    input  logic [len-1:0]   in_pc_branch,
    input  logic             in_flush,
    input  logic             in_idex_mem_read,
    input  logic [4:0]       in_idex_rt,
    output logic [len-1:0]   out_instruction,
    output logic [len-1:0]   out_pc_branch,
    output logic             out_valid,
    output logic             out_pc_enable,
    output logic             out_bubble,
`ifdef IF_ID_STALL_COUNTER_EN
    output logic [31:0]      out_stall_count,
`endif
    output logic             out_halt
);

    logic [len-1:0] r_instruction;
    logic [len-1:0] r_pc_branch;
    logic           r_valid;
    logic           r_halt;

    logic [4:0]     w_rs;
    logic [4:0]     w_rt;
    logic [5:0]     w_opcode;
    logic           w_hazard;
    logic           w_halt_seen;

    assign w_rs     = r_instruction[25:21];
    assign w_rt     = r_instruction[20:16];
    assign w_opcode = r_instruction[31:26];

    // rt is compared even for R/J formats; a spurious stall is harmless, a missed one is not
    assign w_hazard    = r_valid & in_idex_mem_read & (in_idex_rt != 5'd0) &
                         ((in_idex_rt == w_rs) | (in_idex_rt == w_rt));
    assign w_halt_seen = r_valid & (w_opcode == HALT_OPCODE);

    assign out_pc_enable = reset & ~w_hazard & ~w_halt_seen & ~r_halt;
    assign out_bubble    = reset & (w_hazard | r_halt) & ~in_flush;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_instruction <= NOP;
            r_pc_branch   <= '0;
            r_valid       <= 1'b0;
        end else if (in_flush) begin
            r_instruction <= NOP;
            r_pc_branch   <= in_pc_branch;
            r_valid       <= 1'b0;
        end else if (r_halt || w_halt_seen || w_hazard) begin
            r_instruction <= r_instruction;
            r_pc_branch   <= r_pc_branch;
            r_valid       <= r_valid;
        end else begin
            r_instruction <= in_instruction;
            r_pc_branch   <= in_pc_branch;
            r_valid       <= 1'b1;
        end
    end

    // A flushed HALT never latches; once latched only reset clears it
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_halt <= 1'b0;
        end else if (w_halt_seen && !in_flush) begin
            r_halt <= 1'b1;
        end
    end

`ifdef IF_ID_STALL_COUNTER_EN
    logic [31:0] r_stall_count;
    logic        w_count_en;

    assign w_count_en = w_hazard & ~in_flush & ~r_halt & ~w_halt_seen;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_count <= 32'd0;
        end else if (w_count_en && (r_stall_count != 32'hFFFFFFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign out_stall_count = r_stall_count;
`endif

    assign out_instruction = r_instruction;
    assign out_pc_branch   = r_pc_branch;
    assign out_valid       = r_valid;
    assign out_halt        = r_halt;

endmodule
